// File: rtl/pp_stream_gen_if.sv
// Operand/row stream bundle for pp_stream_gen: operation request side and row output side.
interface pp_stream_gen_if #(
  parameter int W = 16,
  parameter int N = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [N-1:0]           in_x;
  logic [W-1:0]           in_y;
  logic                   in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [W+1:0]           out_pp;
  logic [$clog2(N)-1:0]   out_shift;
  logic                   out_last;

  modport master (
    output in_valid, in_x, in_y, in_mode, out_ready,
    input  in_ready, out_valid, out_pp, out_shift, out_last
  );
  modport slave (
    input  in_valid, in_x, in_y, in_mode, out_ready,
    output in_ready, out_valid, out_pp, out_shift, out_last
  );
endinterface

// File: rtl/pp_stream_gen.sv
// Serial partial-product row generator (radix-2 binary or radix-4 Booth per operation).
// Build option PP_STREAM_GEN_SKIP_ZERO_EN: suppress zero rows (all-zero op emits one zero row).
module pp_stream_gen #(
  parameter int W = 16,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  pp_stream_gen_if.slave s_bus
);
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, EMIT} state_t;
  typedef struct packed {
    logic [CW-1:0] idx;
    logic [W+1:0]  pp;
    logic          last;
  } row_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic          r_mode;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_last;
  logic [W+1:0]  r_pp;
  logic [CW-1:0] r_shift;
  logic          w_acc, w_hs;
  row_t          w_first, w_next;

  function automatic logic [W+1:0] pp_of(input logic [N-1:0] x, input logic [W-1:0] y,
                                         input logic m, input int k);
    logic [W+1:0] sy;
    logic [N:0]   xe;
    logic [2:0]   b;
    sy    = {{2{y[W-1]}}, y};
    xe    = {x, 1'b0};
    pp_of = '0;
    if (!m) begin
      // MSB of a two's complement multiplier carries negative weight
      if (x[k]) pp_of = (k == N-1) ? -sy : sy;
    end else begin
      b = xe[2*k+2 -: 3];
      case (b)
        3'b001, 3'b010: pp_of = sy;
        3'b011:         pp_of = sy << 1;
        3'b100:         pp_of = -(sy << 1);
        3'b101, 3'b110: pp_of = -sy;
        default:        pp_of = '0;
      endcase
    end
  endfunction

  // Row to present when starting the search at index start.
  function automatic row_t next_row(input logic [N-1:0] x, input logic [W-1:0] y,
                                    input logic m, input int start);
    row_t r;
    int   rows;
    rows   = m ? N/2 : N;
    r.idx  = '0;
    r.pp   = '0;
    r.last = 1'b1;
`ifdef PP_STREAM_GEN_SKIP_ZERO_EN
    begin
      logic         found;
      logic [W+1:0] p;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (k >= start && k < rows) begin
          p = pp_of(x, y, m, k);
          if (p != '0) begin
            if (!found) begin
              found = 1'b1;
              r.idx = CW'(k);
              r.pp  = p;
            end else begin
              r.last = 1'b0;
            end
          end
        end
      end
    end
`else
    r.idx  = CW'(start);
    if (start < rows) r.pp = pp_of(x, y, m, start);
    r.last = (start == rows - 1);
`endif
    return r;
  endfunction

  function automatic logic [CW-1:0] shift_of(input logic m, input logic [CW-1:0] idx);
    return m ? {idx[CW-2:0], 1'b0} : idx;
  endfunction

  assign s_bus.in_ready  = (r_state == IDLE) | (r_valid & s_bus.out_ready & r_last);
  assign s_bus.out_valid = r_valid;
  assign s_bus.out_pp    = r_pp;
  assign s_bus.out_shift = r_shift;
  assign s_bus.out_last  = r_last;

  assign w_acc   = s_bus.in_valid & s_bus.in_ready;
  assign w_hs    = r_valid & s_bus.out_ready;
  assign w_first = next_row(s_bus.in_x, s_bus.in_y, s_bus.in_mode, 0);
  assign w_next  = next_row(r_x, r_y, r_mode, int'(r_cnt) + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = EMIT;
      EMIT:    if (w_hs && r_last && !w_acc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_pp    <= '0;
      r_shift <= '0;
    end else if (w_acc) begin
      r_x     <= s_bus.in_x;
      r_y     <= s_bus.in_y;
      r_mode  <= s_bus.in_mode;
      r_cnt   <= w_first.idx;
      r_pp    <= w_first.pp;
      r_shift <= shift_of(s_bus.in_mode, w_first.idx);
      r_last  <= w_first.last;
      r_valid <= 1'b1;
    end else if (w_hs) begin
      if (r_last) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_cnt   <= w_next.idx;
        r_pp    <= w_next.pp;
        r_shift <= shift_of(r_mode, w_next.idx);
        r_last  <= w_next.last;
      end
    end
  end
endmodule

// File: doc/pp_stream_gen.md
# pp_stream_gen

Streaming partial-product generator: accepts a signed multiplier/multiplicand pair over a valid/ready handshake and emits the partial-product rows serially, one row per output handshake, each with its shift amount and a last flag. A per-operation mode selects radix-2 binary rows or radix-4 Booth rows. It feeds the sequential shift-accumulate datapath in place of a single-row combinational generator.

## Interface
- W, 16: multiplicand width in bits, two's complement, ≥ 2.
- N, 16: multiplier width in bits, two's complement, even, ≥ 4.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  generator can accept an operation.
- in_x  in  N  multiplier, signed.
- in_y  in  W  multiplicand, signed.
- in_mode  in  1  0 = binary radix-2, 1 = radix-4 Booth.
- out_valid  out  1  row valid.
- out_ready  in  1  consumer takes the row.
- out_pp  out  W+2  row value, signed two's complement.
- out_shift  out  $clog2(N)  left-shift weight of the row.
- out_last  out  1  final row of the operation.

## Operation
- States: IDLE, EMIT. Reset puts the FSM in IDLE with row counter 0, out_valid 0 and out_last 0. out_pp, out_shift and the operand registers reset to 0.
- in_ready = (state == IDLE) | (out_valid & out_ready & out_last).
- Accept occurs on in_valid & in_ready. On accept, in_x, in_y and in_mode are latched, the counter is cleared and the FSM enters EMIT.
- Binary mode has N rows, i = 0..N-1, with shift = i:
  - For i < N-1: pp = x[i] ? sext(y) : 0.
  - Row N-1: pp = x[N-1] ? -sext(y) : 0. This is the negative MSB weight.
- Booth mode has N/2 rows, j = 0..N/2-1, with shift = 2j:
  - Digit d = -2·x[2j+1] + x[2j] + x[2j-1], with x[-1] = 0.
  - pp = d·sext(y), with d in {-2..2}.
- All pp are exact in W+2 bits, including y = -2^(W-1).
- Invariant: Σ out_pp·2^out_shift over one operation = in_x·in_y (signed).
- Rows are emitted in increasing shift order. out_last is asserted on the final row.
- The counter advances only on out_valid & out_ready.
- On the last-row handshake:
  - With in_valid high, the new operation is accepted in the same cycle and EMIT continues.
  - Otherwise the FSM returns to IDLE.
- Inputs are ignored whenever in_ready is 0.

## Timing
- Latency: out_valid rises the cycle after accept, with row 0 presented.
- One row per cycle while out_ready is held high.
- Back-to-back operations have no bubble. Sustained cost per operation: N cycles (binary) or N/2 cycles (Booth).
- Under backpressure, out_pp, out_shift and out_last hold stable while out_valid & !out_ready. out_valid never drops without a handshake.
- Outputs are registered. in_ready is the only combinational output, and it depends on state, out_valid, out_ready and out_last.
- rst asserted at any time, including mid-operation, drops out_valid immediately. The in-flight operation is discarded with no further rows. After release the block is in IDLE with in_ready = 1.
- No handshake completes while rst is asserted.

## Configuration
- PP_STREAM_GEN_SKIP_ZERO_EN defined:
  - Rows with pp == 0 are not emitted.
  - out_last marks the last nonzero row.
  - An operation whose rows are all zero emits exactly one row: pp = 0, shift = 0, last = 1.
  - The counter jumps directly to the next nonzero row, so there are no idle cycles between emitted rows.
- Undefined: every row is emitted, N rows (binary) or N/2 rows (Booth).
- The summation invariant holds in both builds.

## Test plan
All scenarios use W = N = 16 with the macro undefined unless stated.
- Binary x=3, y=5, out_ready=1 → 16 rows. shift 0 and 1 have pp=5; all other rows pp=0. out_last only on shift 15. out_valid is high in cycles 1..16 after accept.
- Booth x=3, y=5 → 8 rows: shift 0 pp=-5 (18'h3FFFB), shift 2 pp=5, remaining rows 0, last on shift 14. The sum reconstructs 15.
- Extremes, x=y=-32768:
  - Binary: row 15 pp = 18'h08000.
  - Booth: row shift 14 pp = 18'h10000.
  - Both reconstruct 2^30.
- Backpressure and back-to-back:
  - Toggle out_ready pseudo-randomly. Rows hold stable while stalled.
  - A second operation is presented with in_valid during the last-row handshake and is accepted in that cycle. Its row 0 appears the next cycle.
- Assert rst for one cycle during row 5 of a binary operation → out_valid=0 immediately, in_ready=1 after release. A new operation x=1, y=7 yields a correct stream.
- Macro defined:
  - Binary x=3, y=5 → exactly two rows, (5, shift 0) and (5, shift 1, last).
  - x=0 → single row (0, shift 0, last).
